// File: rtl/keypad_scan_decoder_if.sv
// Keypad-side and command-side signals of the keypad scan decoder.
// The decoder takes the master modport; the keypad/consumer side takes the slave modport.
interface keypad_scan_decoder_if;
  logic [3:0] kp_row;
  logic [3:0] kp_col;
  logic [3:0] key_code;
  logic       key_held;
  logic       key_valid;
  logic [3:0] player_cmd;

  modport master (
    input  kp_row,
    output kp_col, key_code, key_held, key_valid, player_cmd
  );

  modport slave (
    output kp_row,
    input  kp_col, key_code, key_held, key_valid, player_cmd
  );
endinterface

// File: rtl/keypad_scan_decoder.sv
// 4x4 matrix keypad scanner: walks one-cold columns, decodes whole frames, debounces them,
// and emits one command pulse per accepted press, with optional auto-repeat while held.
module keypad_scan_decoder #(
  parameter int SETTLE_CYCLES   = 100000,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int REPEAT_FRAMES   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  keypad_scan_decoder_if.master  kp
);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int RW = $clog2(REPEAT_FRAMES + 2);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_FULL    = DW'(DEBOUNCE_FRAMES);
  localparam logic [RW-1:0] REP_FULL    = RW'(REPEAT_FRAMES);

  logic [3:0]    row_meta_q, row_meta_d, row_sync_q, row_sync_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [3:0]    acc_code_q, acc_code_d;
  logic          prev_key_q, prev_key_d;
  logic [3:0]    prev_code_q, prev_code_d;
  logic [DW-1:0] stable_cnt_q, stable_cnt_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          key_held_q, key_held_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    player_cmd_q, player_cmd_d;

  logic [2:0]    col_lows;
  logic [1:0]    col_row;
  logic [2:0]    tot_raw;
  logic [1:0]    frame_cnt;
  logic [3:0]    frame_code;
  logic          res_key, same_res, differs;
  logic [DW-1:0] stable_inc;
  logic [RW-1:0] rep_inc;

  function automatic logic [3:0] key_map(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    case ({col, row})
      4'h0: code = 4'h1;  4'h1: code = 4'h4;  4'h2: code = 4'h7;  4'h3: code = 4'h0;
      4'h4: code = 4'h2;  4'h5: code = 4'h5;  4'h6: code = 4'h8;  4'h7: code = 4'hF;
      4'h8: code = 4'h3;  4'h9: code = 4'h6;  4'hA: code = 4'h9;  4'hB: code = 4'hE;
      4'hC: code = 4'hA;  4'hD: code = 4'hB;  4'hE: code = 4'hC;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Low-row count saturates at 2: anything beyond a single key is rejected as ghosting.
  always_comb begin
    col_lows = 3'd0;
    col_row  = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_q[r]) begin
        col_lows = col_lows + 3'd1;
        col_row  = 2'(r);
      end
    end
    tot_raw    = {1'b0, acc_cnt_q} + col_lows;
    frame_cnt  = (tot_raw >= 3'd2) ? 2'd2 : tot_raw[1:0];
    frame_code = (acc_cnt_q == 2'd0) ? key_map(col_idx_q, col_row) : acc_code_q;
    res_key    = (frame_cnt == 2'd1);
  end

  always_comb begin
    row_meta_d   = kp.kp_row;
    row_sync_d   = row_meta_q;
    settle_cnt_d = settle_cnt_q + SW'(1);
    col_idx_d    = col_idx_q;
    acc_cnt_d    = acc_cnt_q;
    acc_code_d   = acc_code_q;
    prev_key_d   = prev_key_q;
    prev_code_d  = prev_code_q;
    stable_cnt_d = stable_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    key_held_d   = key_held_q;
    key_code_d   = key_code_q;
    key_valid_d  = 1'b0;
    player_cmd_d = 4'h0;
    same_res     = (res_key == prev_key_q) && (!res_key || frame_code == prev_code_q);
    stable_inc   = (stable_cnt_q == DEB_FULL) ? DEB_FULL : stable_cnt_q + DW'(1);
    differs      = res_key ? (!key_held_q || frame_code != key_code_q) : key_held_q;
    rep_inc      = rep_cnt_q + RW'(1);

    if (settle_cnt_q == SETTLE_LAST) begin
      settle_cnt_d = '0;
      col_idx_d    = col_idx_q + 2'd1;
      acc_cnt_d    = frame_cnt;
      acc_code_d   = frame_code;
      if (col_idx_q == 2'd3) begin
        acc_cnt_d    = 2'd0;
        prev_key_d   = res_key;
        prev_code_d  = frame_code;
        stable_cnt_d = same_res ? stable_inc : DW'(1);
        if (stable_cnt_d == DEB_FULL && differs) begin
          key_held_d = res_key;
          rep_cnt_d  = '0;
          if (res_key) begin
            key_code_d   = frame_code;
            key_valid_d  = 1'b1;
            player_cmd_d = frame_code;
          end
        end else if (REPEAT_FRAMES > 0 && key_held_q) begin
          if (rep_inc == REP_FULL) begin
            rep_cnt_d    = '0;
            key_valid_d  = 1'b1;
            player_cmd_d = key_code_q;
          end else begin
            rep_cnt_d = rep_inc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta_q   <= 4'hF;
      row_sync_q   <= 4'hF;
      settle_cnt_q <= '0;
      col_idx_q    <= 2'd0;
      acc_cnt_q    <= 2'd0;
      acc_code_q   <= 4'h0;
      prev_key_q   <= 1'b0;
      prev_code_q  <= 4'h0;
      stable_cnt_q <= '0;
      rep_cnt_q    <= '0;
      key_held_q   <= 1'b0;
      key_code_q   <= 4'h0;
      key_valid_q  <= 1'b0;
      player_cmd_q <= 4'h0;
    end else begin
      row_meta_q   <= row_meta_d;
      row_sync_q   <= row_sync_d;
      settle_cnt_q <= settle_cnt_d;
      col_idx_q    <= col_idx_d;
      acc_cnt_q    <= acc_cnt_d;
      acc_code_q   <= acc_code_d;
      prev_key_q   <= prev_key_d;
      prev_code_q  <= prev_code_d;
      stable_cnt_q <= stable_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      key_held_q   <= key_held_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      player_cmd_q <= player_cmd_d;
    end
  end

  assign kp.kp_col     = ~(4'b0001 << col_idx_q);
  assign kp.key_code   = key_code_q;
  assign kp.key_held   = key_held_q;
  assign kp.key_valid  = key_valid_q;
  assign kp.player_cmd = player_cmd_q;
endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Bench for keypad_scan_decoder: a simulated key matrix feeds two instances (no repeat, repeat=4)
// and a frame-level model of debounce/repeat predicts every pulse.
module tb_keypad_scan_decoder;
  localparam int SETTLE = 8;
  localparam int DEB    = 3;
  localparam int REP_B  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pressed = 16'h0000;
  logic [3:0]  kp_row;
  int          total = 0;
  int          bad = 0;
  int          frame_no = 0;

  int hist[$];
  int deb_m = -1;
  int code_m = 0;
  int since_m = 0;

  typedef struct {
    logic [15:0] keys;
    logic        valid;
    logic [3:0]  cmd;
    logic [3:0]  code;
    logic        held;
  } vec_t;
  vec_t vecs[19];

  keypad_scan_decoder_if ifa ();
  keypad_scan_decoder_if ifb ();

  keypad_scan_decoder #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_FRAMES(DEB), .REPEAT_FRAMES(0)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (ifa)
  );

  keypad_scan_decoder #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_FRAMES(DEB), .REPEAT_FRAMES(REP_B)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (ifb)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] key_at(input int c, input int r);
    logic [3:0] grid [4][4];
    grid = '{'{4'h1, 4'h4, 4'h7, 4'h0}, '{4'h2, 4'h5, 4'h8, 4'hF},
             '{4'h3, 4'h6, 4'h9, 4'hE}, '{4'hA, 4'hB, 4'hC, 4'hD}};
    return grid[c][r];
  endfunction

  // Physical matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    kp_row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!ifa.kp_col[c] && pressed[key_at(c, r)]) kp_row[r] = 1'b0;
  end
  assign ifa.kp_row = kp_row;
  assign ifb.kp_row = kp_row;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s (frame %0d): got %0d expected %0d", name, frame_no, act, exp);
    end
  endtask

  function automatic int frame_result(input logic [15:0] keys);
    int n = 0;
    int found = -1;
    for (int k = 0; k < 16; k++)
      if (keys[k]) begin
        n++;
        found = k;
      end
    return (n == 1) ? found : -1;
  endfunction

  // Accept when the last DEB frame results agree and differ from the held state.
  task automatic model_frame(input int res, output int ea, output int eb);
    bit all_same;
    hist.push_back(res);
    if (hist.size() > DEB) void'(hist.pop_front());
    all_same = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != res) all_same = 1'b0;
    ea = -1;
    eb = -1;
    if (all_same && res != deb_m) begin
      deb_m = res;
      if (res >= 0) begin
        code_m  = res;
        ea      = res;
        eb      = res;
        since_m = 0;
      end
    end else if (deb_m >= 0) begin
      since_m++;
      if (since_m == REP_B) begin
        eb      = deb_m;
        since_m = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_kp_col", int'(ifa.kp_col), 4'b1110);
    chk("rst_key_code", int'(ifa.key_code), 0);
    chk("rst_key_held", int'(ifa.key_held), 0);
    chk("rst_key_valid", int'(ifa.key_valid), 0);
    chk("rst_player_cmd", int'(ifa.player_cmd), 0);
    chk("rst_b_key_held", int'(ifb.key_held), 0);
    chk("rst_b_key_code", int'(ifb.key_code), 0);
    rst_n = 1'b1;
    hist.delete();
    deb_m    = -1;
    code_m   = 0;
    since_m  = 0;
    frame_no = 0;
    $display("reset applied");
  endtask

  task automatic run_frame(input logic [15:0] keys, output logic va, output logic vb);
    int ea, eb;
    logic [3:0] col_exp;
    pressed = keys;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k % 8 == 4) begin
        col_exp = 4'b0001 << ((k - 4) / 8);
        col_exp = ~col_exp;
        chk("kp_col", int'(ifa.kp_col), int'(col_exp));
      end
      if (k < 32) begin
        chk("midframe_valid_a", int'(ifa.key_valid), 0);
        chk("midframe_valid_b", int'(ifb.key_valid), 0);
      end
      if (!ifa.key_valid) chk("idle_cmd_a", int'(ifa.player_cmd), 0);
      if (!ifb.key_valid) chk("idle_cmd_b", int'(ifb.player_cmd), 0);
    end
    frame_no++;
    model_frame(frame_result(keys), ea, eb);
    chk("valid_a", int'(ifa.key_valid), (ea >= 0) ? 1 : 0);
    chk("cmd_a", int'(ifa.player_cmd), (ea >= 0) ? ea : 0);
    chk("code_a", int'(ifa.key_code), code_m);
    chk("held_a", int'(ifa.key_held), (deb_m >= 0) ? 1 : 0);
    chk("valid_b", int'(ifb.key_valid), (eb >= 0) ? 1 : 0);
    chk("cmd_b", int'(ifb.player_cmd), (eb >= 0) ? eb : 0);
    chk("held_b", int'(ifb.key_held), (deb_m >= 0) ? 1 : 0);
    va = ifa.key_valid;
    vb = ifb.key_valid;
    $display("frame %0d keys=%04h a:valid=%0d cmd=%h code=%h held=%0d b:valid=%0d cmd=%h",
             frame_no, keys, ifa.key_valid, ifa.player_cmd, ifa.key_code, ifa.key_held,
             ifb.key_valid, ifb.player_cmd);
  endtask

  initial begin
    logic        va, vb;
    int          ea, eb;
    int          n_pulse;
    logic [15:0] keys;
    int          sel;

    vecs[0]  = '{16'h0004, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{16'h0004, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[2]  = '{16'h0004, 1'b1, 4'h2, 4'h2, 1'b1};
    vecs[3]  = '{16'h0004, 1'b0, 4'h0, 4'h2, 1'b1};
    vecs[4]  = '{16'h0000, 1'b0, 4'h0, 4'h2, 1'b1};
    vecs[5]  = '{16'h0000, 1'b0, 4'h0, 4'h2, 1'b1};
    vecs[6]  = '{16'h0000, 1'b0, 4'h0, 4'h2, 1'b0};
    vecs[7]  = '{16'h0060, 1'b0, 4'h0, 4'h2, 1'b0};
    vecs[8]  = '{16'h0060, 1'b0, 4'h0, 4'h2, 1'b0};
    vecs[9]  = '{16'h0060, 1'b0, 4'h0, 4'h2, 1'b0};
    vecs[10] = '{16'h0020, 1'b0, 4'h0, 4'h2, 1'b0};
    vecs[11] = '{16'h0020, 1'b0, 4'h0, 4'h2, 1'b0};
    vecs[12] = '{16'h0020, 1'b1, 4'h5, 4'h5, 1'b1};
    vecs[13] = '{16'h0001, 1'b0, 4'h0, 4'h5, 1'b1};
    vecs[14] = '{16'h0001, 1'b0, 4'h0, 4'h5, 1'b1};
    vecs[15] = '{16'h0001, 1'b1, 4'h0, 4'h0, 1'b1};
    vecs[16] = '{16'h8000, 1'b0, 4'h0, 4'h0, 1'b1};
    vecs[17] = '{16'h8000, 1'b0, 4'h0, 4'h0, 1'b1};
    vecs[18] = '{16'h8000, 1'b1, 4'hF, 4'hF, 1'b1};

    // Press '2', release, two-key ghosting, direct key changes, key 0 giving cmd 0.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      run_frame(vecs[i].keys, va, vb);
      chk("vec_valid", int'(ifa.key_valid), int'(vecs[i].valid));
      chk("vec_cmd", int'(ifa.player_cmd), int'(vecs[i].cmd));
      chk("vec_code", int'(ifa.key_code), int'(vecs[i].code));
      chk("vec_held", int'(ifa.key_held), int'(vecs[i].held));
    end

    // Auto-repeat while '8' is held for 20 frames.
    do_reset();
    for (int f = 1; f <= 20; f++) begin
      run_frame(16'h0100, va, vb);
      chk("repeat_b_pulse", int'(vb), (f >= 3 && (f - 3) % 4 == 0) ? 1 : 0);
      chk("norepeat_a_pulse", int'(va), (f == 3) ? 1 : 0);
    end

    // Row0 bounce on key '2' every 20 clocks for 4 frames, then a clean hold and release.
    do_reset();
    n_pulse = 0;
    for (int t = 0; t < 128; t++) begin
      pressed = (((t / 20) % 2) == 0) ? 16'h0004 : 16'h0000;
      @(negedge clk);
      chk("bounce_quiet_a", int'(ifa.key_valid), 0);
      chk("bounce_quiet_b", int'(ifb.key_valid), 0);
      n_pulse += int'(ifa.key_valid);
    end
    for (int f = 0; f < 4; f++) model_frame(-1, ea, eb);
    frame_no = 4;
    for (int f = 0; f < 4; f++) begin
      run_frame(16'h0004, va, vb);
      chk("bounce_pulse_frame", int'(va), (f == 2) ? 1 : 0);
      n_pulse += int'(va);
    end
    for (int f = 0; f < 3; f++) begin
      run_frame(16'h0000, va, vb);
      n_pulse += int'(va);
    end
    chk("bounce_pulse_count", n_pulse, 1);
    chk("bounce_released", int'(ifa.key_held), 0);

    // Reset mid-frame while '4' is held; it must debounce again from scratch.
    do_reset();
    for (int f = 0; f < 3; f++) run_frame(16'h0010, va, vb);
    chk("pre_reset_code", int'(ifa.key_code), 4);
    for (int k = 0; k < 13; k++) @(negedge clk);
    do_reset();
    for (int f = 0; f < 4; f++) begin
      run_frame(16'h0010, va, vb);
      chk("post_reset_pulse", int'(va), (f == 2) ? 1 : 0);
    end

    // Random sticky key activity against the model.
    do_reset();
    keys = 16'h0000;
    for (int f = 0; f < 40; f++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 5) keys = keys;
      else if (sel < 7) keys = 16'h0000;
      else if (sel < 9) keys = 16'h0001 << $urandom_range(0, 15);
      else keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      run_frame(keys, va, vb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
